rr_trace_hb_decoder: RTL and testbench

// Replay-side inverse of the record-side happen-before packer. Consumes trace

---
 rtl/rr_trace_hb_decoder_if.sv | 37 +++
 rtl/rr_trace_hb_decoder.sv | 97 +++++++++
 tb/tb_rr_trace_hb_decoder.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/rr_trace_hb_decoder_if.sv
// Trace-unit read stream, end-completion pulses and decoded-unit output bundle for the
// happen-before decoder. The slave modport is the decoder's view.
interface rr_trace_hb_decoder_if #(
  parameter int unsigned LOGB_CHANNEL_CNT = 4,
  parameter int unsigned LOGE_CHANNEL_CNT = 4,
  parameter int unsigned LOGB_DATA_WIDTH  = 512,
  parameter int unsigned OFFSET_WIDTH     = 10
);
  localparam int unsigned FullWidth = LOGB_CHANNEL_CNT + LOGE_CHANNEL_CNT + LOGB_DATA_WIDTH;

  logic                        in_valid;
  logic                        in_ready;
  logic [FullWidth-1:0]        in_data;
  logic [OFFSET_WIDTH-1:0]     in_len;
  logic [LOGE_CHANNEL_CNT-1:0] loge_done;
  logic                        out_valid;
  logic                        out_ready;
  logic [LOGB_CHANNEL_CNT-1:0] out_logb;
  logic [LOGB_DATA_WIDTH-1:0]  out_data;
  logic [OFFSET_WIDTH-1:0]     out_len;
  logic [LOGE_CHANNEL_CNT-1:0] pending_loge;
  logic [31:0]                 stall_cycles;
  logic                        hb_err;
  logic                        len_err;

  modport slave (
    input  in_valid, in_data, in_len, loge_done, out_ready,
    output in_ready, out_valid, out_logb, out_data, out_len, pending_loge, stall_cycles,
           hb_err, len_err
  );

  modport master (
    output in_valid, in_data, in_len, loge_done, out_ready,
    input  in_ready, out_valid, out_logb, out_data, out_len, pending_loge, stall_cycles,
           hb_err, len_err
  );
endinterface

// File: rtl/rr_trace_hb_decoder.sv
// Replay-side happen-before decoder: holds each trace unit until every transaction end it
// names has been banked as a credit, then releases its logb mask and payload.
module rr_trace_hb_decoder #(
  parameter int unsigned LOGB_CHANNEL_CNT = 4,
  parameter int unsigned LOGE_CHANNEL_CNT = 4,
  parameter int unsigned LOGB_DATA_WIDTH  = 512,
  parameter int unsigned OFFSET_WIDTH     = 10
) (
  input logic                  clk,
  input logic                  rst,
  rr_trace_hb_decoder_if.slave bus
);
  localparam int unsigned LB = LOGB_CHANNEL_CNT;
  localparam int unsigned LE = LOGE_CHANNEL_CNT;
  localparam int unsigned DW = LOGB_DATA_WIDTH;
  localparam int unsigned OW = OFFSET_WIDTH;
  localparam logic [OW-1:0] HdrLen = OW'(LB + LE);

  typedef enum logic [1:0] {StIdle, StWait, StIssue} state_e;

  state_e          state_q, state_d;
  logic [LB-1:0]   logb_q;
  logic [LE-1:0]   req_q;
  logic [DW-1:0]   data_q;
  logic [OW-1:0]   len_q;
  logic [LE-1:0]   credit_q, credit_d;
  logic [31:0]     stall_q, stall_d;
  logic            hb_err_q, hb_err_d;
  logic            len_err_q;
  logic            accept, len_short;
  logic [LE-1:0]   pending, consume;

  assign accept    = bus.in_valid && (state_q == StIdle);
  assign len_short = bus.in_len < HdrLen;

  always_comb begin
    state_d  = state_q;
    pending  = '0;
    consume  = '0;
    unique case (state_q)
      StIdle:  if (accept) state_d = StWait;
      StWait: begin
        pending = req_q & ~credit_q;
        if (pending == '0) begin
          consume = req_q;
          state_d = StIssue;
        end
      end
      StIssue: if (bus.out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // A consumed credit re-armed by a same-cycle pulse is legal, not an overflow.
    credit_d = (credit_q & ~consume) | bus.loge_done;
    hb_err_d = hb_err_q | (|(bus.loge_done & credit_q & ~consume));

    stall_d = stall_q;
    if ((pending != '0) && (stall_q != '1)) stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      logb_q    <= '0;
      req_q     <= '0;
      data_q    <= '0;
      len_q     <= '0;
      credit_q  <= '0;
      stall_q   <= '0;
      hb_err_q  <= 1'b0;
      len_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      stall_q  <= stall_d;
      hb_err_q <= hb_err_d;
      if (accept) begin
        logb_q <= bus.in_data[LB-1:0];
        req_q  <= bus.in_data[LB+LE-1:LB];
        data_q <= bus.in_data[LB+LE+DW-1:LB+LE];
        len_q  <= len_short ? '0 : bus.in_len - HdrLen;
        if (len_short) len_err_q <= 1'b1;
      end
    end
  end

  // Decoded fields only show while the unit is being offered.
  assign bus.in_ready     = (state_q == StIdle);
  assign bus.out_valid    = (state_q == StIssue);
  assign bus.out_logb     = bus.out_valid ? logb_q : '0;
  assign bus.out_data     = bus.out_valid ? data_q : '0;
  assign bus.out_len      = bus.out_valid ? len_q : '0;
  assign bus.pending_loge = pending;
  assign bus.stall_cycles = stall_q;
  assign bus.hb_err       = hb_err_q;
  assign bus.len_err      = len_err_q;
endmodule

// File: tb/tb_rr_trace_hb_decoder.sv
// Bench for rr_trace_hb_decoder: directed ordering scenarios plus random traffic, all
// checked every cycle against a unit-queue / credit-set reference model.
module tb_rr_trace_hb_decoder;
  localparam int unsigned LB = 4;
  localparam int unsigned LE = 4;
  localparam int unsigned DW = 512;
  localparam int unsigned OW = 10;
  localparam int unsigned FW = LB + LE + DW;
  localparam int unsigned CW = 512;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  rr_trace_hb_decoder_if #(
    .LOGB_CHANNEL_CNT(LB), .LOGE_CHANNEL_CNT(LE), .LOGB_DATA_WIDTH(DW), .OFFSET_WIDTH(OW)
  ) bus ();

  rr_trace_hb_decoder #(
    .LOGB_CHANNEL_CNT(LB), .LOGE_CHANNEL_CNT(LE), .LOGB_DATA_WIDTH(DW), .OFFSET_WIDTH(OW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: at most one unit held; it is granted once all its ends are banked.
  typedef struct packed {
    logic [LB-1:0] logb;
    logic [LE-1:0] req;
    logic [DW-1:0] data;
    logic [OW-1:0] len;
  } unit_t;

  unit_t         held[$];
  bit            granted;
  logic [LE-1:0] cred;
  longint        stall;
  bit            m_hb, m_lerr;

  task automatic model_reset();
    held.delete();
    granted = 0;
    cred    = '0;
    stall   = 0;
    m_hb    = 0;
    m_lerr  = 0;
  endtask

  function automatic logic [LE-1:0] awaited();
    if (held.size() != 0 && !granted) return held[0].req & ~cred;
    return '0;
  endfunction

  task automatic check_outputs(input string pfx);
    unit_t h;
    bit    rel;
    h   = '0;
    rel = (held.size() != 0) && granted;
    if (rel) h = held[0];
    check({pfx, "in_ready"},  CW'(bus.in_ready),     CW'(held.size() == 0));
    check({pfx, "out_valid"}, CW'(bus.out_valid),    CW'(rel));
    check({pfx, "out_logb"},  CW'(bus.out_logb),     CW'(h.logb));
    check({pfx, "out_data"},  CW'(bus.out_data),     CW'(h.data));
    check({pfx, "out_len"},   CW'(bus.out_len),      CW'(h.len));
    check({pfx, "pending"},   CW'(bus.pending_loge), CW'(awaited()));
    check({pfx, "stall"},     CW'(bus.stall_cycles), CW'(stall));
    check({pfx, "hb_err"},    CW'(bus.hb_err),       CW'(m_hb));
    check({pfx, "len_err"},   CW'(bus.len_err),      CW'(m_lerr));
  endtask

  // One clock: check current outputs, drive inputs for the next edge, advance the model.
  task automatic step(input bit iv, input logic [FW-1:0] id, input logic [OW-1:0] il,
                      input logic [LE-1:0] ld, input bit ordy);
    logic [LE-1:0] pend, consume;
    bit            waiting;
    unit_t         u;
    @(negedge clk);
    check_outputs("");
    bus.in_valid  = iv;
    bus.in_data   = id;
    bus.in_len    = il;
    bus.loge_done = ld;
    bus.out_ready = ordy;

    waiting = (held.size() != 0) && !granted;
    pend    = awaited();
    consume = (waiting && pend == '0) ? held[0].req : '0;
    if ((ld & cred & ~consume) != '0) m_hb = 1;
    if (pend != '0 && stall < 64'hFFFF_FFFF) stall++;
    cred = (cred & ~consume) | ld;
    if (held.size() == 0) begin
      if (iv) begin
        u.logb = id[LB-1:0];
        u.req  = id[LB+LE-1:LB];
        u.data = id[FW-1:LB+LE];
        if (il < OW'(LB + LE)) begin
          u.len  = '0;
          m_lerr = 1;
        end else begin
          u.len = il - OW'(LB + LE);
        end
        held.push_back(u);
        granted = 0;
      end
    end else if (!granted) begin
      if (pend == '0) granted = 1;
    end else if (ordy) begin
      void'(held.pop_front());
      granted = 0;
    end
  endtask

  task automatic idle(input int n, input bit ordy);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, '0, ordy);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_len    = '0;
    bus.loge_done = '0;
    bus.out_ready = 1'b0;
    model_reset();
    #1;
    check_outputs("rst_");
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic [FW-1:0] mk(input logic [LB-1:0] logb, input logic [LE-1:0] loge);
    logic [DW+31:0] p;
    for (int i = 0; i < DW; i += 32) p[i+:32] = $urandom;
    return {p[DW-1:0], loge, logb};
  endfunction

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_len    = '0;
    bus.loge_done = '0;
    bus.out_ready = 1'b0;
    model_reset();
    do_reset();

    // Begin-only unit, no ends awaited.
    step(1'b1, mk(4'b0011, 4'b0000), OW'(LB + LE + 64), '0, 1'b1);
    idle(4, 1'b1);

    // Two awaited ends arriving while the unit waits.
    step(1'b1, mk(4'b0001, 4'b0101), OW'(LB + LE + 32), '0, 1'b1);
    idle(2, 1'b1);
    step(1'b0, '0, '0, 4'b0001, 1'b1);
    idle(2, 1'b1);
    step(1'b0, '0, '0, 4'b0100, 1'b1);
    idle(4, 1'b1);

    // End banked well before its unit arrives.
    step(1'b0, '0, '0, 4'b0010, 1'b1);
    idle(10, 1'b1);
    step(1'b1, mk(4'b1000, 4'b0010), OW'(LB + LE + 8), '0, 1'b1);
    idle(4, 1'b1);

    // Double end on channel 3 overflows the credit.
    step(1'b0, '0, '0, 4'b1000, 1'b1);
    step(1'b0, '0, '0, 4'b1000, 1'b1);
    idle(3, 1'b1);

    // Backpressure in ISSUE, then a short-length flush unit.
    step(1'b1, mk(4'b0110, 4'b0000), OW'(LB + LE + 100), '0, 1'b0);
    idle(20, 1'b0);
    idle(3, 1'b1);
    step(1'b1, mk(4'b0000, 4'b0000), OW'(3), '0, 1'b1);
    idle(4, 1'b1);

    // Reset while waiting with credits banked: credits must be forgotten.
    do_reset();
    step(1'b0, '0, '0, 4'b1010, 1'b1);
    step(1'b1, mk(4'b0001, 4'b0101), OW'(LB + LE + 16), '0, 1'b1);
    idle(3, 1'b1);
    do_reset();
    step(1'b1, mk(4'b0010, 4'b1010), OW'(LB + LE + 16), '0, 1'b1);
    idle(4, 1'b1);
    step(1'b0, '0, '0, 4'b1010, 1'b1);
    idle(4, 1'b1);

    // Random traffic.
    for (int r = 0; r < 3; r++) begin
      do_reset();
      for (int c = 0; c < 3000; c++) begin
        logic [LE-1:0] ld;
        logic [OW-1:0] il;
        for (int b = 0; b < int'(LE); b++) ld[b] = ($urandom_range(0, 15) == 0);
        il = ($urandom_range(0, 7) == 0) ? OW'($urandom_range(0, LB + LE - 1))
                                         : OW'($urandom_range(LB + LE, FW));
        step(1'($urandom_range(0, 1)), mk(4'($urandom), 4'($urandom)), il, ld,
             ($urandom_range(0, 3) != 0));
      end
    end

    @(negedge clk);
    check_outputs("final_");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
